// File: rtl/fpu_addsub_issue.sv
// Issue stage in front of a multi-cycle FP adder: queues add/sub requests,
// dispatches one at a time and returns results in order with their tags.
module fpu_addsub_issue #(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_sub,
    input  logic [TAG_W-1:0]            req_tag,
    input  logic [31:0]                 req_a,
    input  logic [31:0]                 req_b,
    output logic                        fadd_en,
    output logic [31:0]                 fadd_a,
    output logic [31:0]                 fadd_b,
    input  logic [31:0]                 fadd_result,
    input  logic                        fadd_done,
    input  logic                        fadd_busy,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [TAG_W-1:0]            rsp_tag,
    output logic [31:0]                 rsp_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + TAG_W + 64;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    logic [EW-1:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    state_t           state_q, state_d;
    logic             fadd_en_q, fadd_en_d;
    logic [31:0]      fadd_a_q, fadd_a_d, fadd_b_q, fadd_b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             push, pop;

    logic [EW-1:0]    head;
    logic             head_sub;
    logic [TAG_W-1:0] head_tag;
    logic [31:0]      head_a, head_b;

    // Ready comes only from the registered count, so a full queue stays full for the cycle of a pop.
    assign req_ready = (count_q != CW'(FIFO_DEPTH));
    assign push      = req_valid && req_ready;
    assign head      = mem_q[rd_ptr_q];
    assign {head_sub, head_tag, head_a, head_b} = head;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_sub, req_tag, req_a, req_b};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            fadd_en_q   <= 1'b0;
            fadd_a_q    <= '0;
            fadd_b_q    <= '0;
            tag_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            fadd_en_q   <= fadd_en_d;
            fadd_a_q    <= fadd_a_d;
            fadd_b_q    <= fadd_b_d;
            tag_q       <= tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0 && !fadd_busy) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    if (fadd_done) state_d = HOLD;
            HOLD:    if (rsp_valid_q && rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Subtraction is a sign flip on b; operands are otherwise passed bit-exact.
    always_comb begin
        fadd_en_d   = 1'b0;
        fadd_a_d    = fadd_a_q;
        fadd_b_d    = fadd_b_q;
        tag_d       = tag_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    fadd_en_d = 1'b1;
                    fadd_a_d  = head_a;
                    fadd_b_d  = {head_b[31] ^ head_sub, head_b[30:0]};
                    tag_d     = head_tag;
                end
            end
            WAIT: begin
                if (fadd_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = fadd_result;
                    rsp_tag_d   = tag_q;
                end
            end
            HOLD: begin
                if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign fadd_en    = fadd_en_q;
    assign fadd_a     = fadd_a_q;
    assign fadd_b     = fadd_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_tag    = rsp_tag_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_fpu_addsub_issue.sv
// Scoreboard bench for fpu_addsub_issue with a behavioural multi-cycle adder.
module tb_fpu_addsub_issue;
    localparam int FIFO_DEPTH = 4;
    localparam int TAG_W      = 4;

    logic             clk, rstn;
    logic             req_valid, req_ready, req_sub;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      req_a, req_b;
    logic             fadd_en;
    logic [31:0]      fadd_a, fadd_b, fadd_result;
    logic             fadd_done, fadd_busy, busy_model, busy_force;
    logic             rsp_valid, rsp_ready;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_data;
    logic [2:0]       fifo_count;

    fpu_addsub_issue #(.FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
        .req_tag(req_tag), .req_a(req_a), .req_b(req_b),
        .fadd_en(fadd_en), .fadd_a(fadd_a), .fadd_b(fadd_b),
        .fadd_result(fadd_result), .fadd_done(fadd_done), .fadd_busy(fadd_busy),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
        .rsp_data(rsp_data), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fadd_busy = busy_model | busy_force;

    int checks = 0, failures = 0;
    int acc_n = 0, iss_n = 0, en_pulses = 0, rsp_n = 0, lat_fixed = 0;
    logic [63:0] iss_q[$];
    logic [TAG_W+31:0] rsp_q[$];
    logic [31:0] last_fadd_b, last_rsp_data;
    logic [TAG_W-1:0] last_rsp_tag;
    logic prev_valid, prev_hs, prev_en, toggling;
    logic [31:0] prev_data;
    logic [TAG_W-1:0] prev_tag;

    // Stand-in for the floating-point adder: exact for the two directed cases, a fixed mix otherwise.
    function automatic logic [31:0] adder_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
        if (a == 32'h4040_0000 && b == 32'hBF80_0000) return 32'h4000_0000;
        return (a * 32'd3) ^ {b[15:0], b[31:16]} ^ 32'hA5A5_0F0F;
    endfunction

    initial begin
        logic [31:0] ra, rb;
        int lat;
        busy_model = 1'b0; fadd_done = 1'b0; fadd_result = '0;
        forever begin
            @(negedge clk);
            if (fadd_en) begin
                ra = fadd_a; rb = fadd_b; busy_model = 1'b1;
                lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 5));
                repeat (lat) @(negedge clk);
                fadd_result = adder_fn(ra, rb);
                fadd_done = 1'b1;
                @(negedge clk);
                fadd_done = 1'b0;
                busy_model = 1'b0;
            end
        end
    end

    // Reference model: each accepted request yields one issue of (a, b or -b) and one response.
    always @(posedge clk) begin
        if (!rstn) begin
            acc_n <= 0;
            iss_q.delete();
            rsp_q.delete();
        end else if (req_valid && req_ready) begin
            acc_n <= acc_n + 1;
            iss_q.push_back({req_a, req_b ^ {req_sub, 31'b0}});
            rsp_q.push_back({req_tag, adder_fn(req_a, req_b ^ {req_sub, 31'b0})});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [63:0] ei;
        logic [TAG_W+31:0] er;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                iss_n = 0; prev_valid = 1'b0; prev_hs = 1'b0; prev_en = 1'b0;
            end else begin
                if (fadd_en) begin
                    en_pulses++;
                    last_fadd_b = fadd_b;
                    chk("fadd_en_width", 64'(prev_en), 64'd0);
                    if (iss_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL issue_extra: fadd_en with no queued request, fadd_a=%0h", fadd_a);
                    end else begin
                        ei = iss_q.pop_front();
                        chk("fadd_a", 64'(fadd_a), 64'(ei[63:32]));
                        chk("fadd_b", 64'(fadd_b), 64'(ei[31:0]));
                    end
                    iss_n++;
                end
                chk("fifo_count", 64'(fifo_count), 64'(acc_n - iss_n));
                chk("req_ready", 64'(req_ready), 64'((acc_n - iss_n) != FIFO_DEPTH));
                if (prev_valid && !prev_hs) begin
                    chk("rsp_valid_hold", 64'(rsp_valid), 64'd1);
                    chk("rsp_data_hold", 64'(rsp_data), 64'(prev_data));
                    chk("rsp_tag_hold", 64'(rsp_tag), 64'(prev_tag));
                end
                if (rsp_valid && rsp_ready) begin
                    rsp_n++;
                    last_rsp_data = rsp_data;
                    last_rsp_tag = rsp_tag;
                    if (rsp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL rsp_extra: unexpected response tag=%0h data=%0h", rsp_tag, rsp_data);
                    end else begin
                        er = rsp_q.pop_front();
                        chk("rsp_tag", 64'(rsp_tag), 64'(er[TAG_W+31:32]));
                        chk("rsp_data", 64'(rsp_data), 64'(er[31:0]));
                    end
                end
                prev_en = fadd_en;
                prev_valid = rsp_valid;
                prev_hs = rsp_valid && rsp_ready;
                prev_data = rsp_data;
                prev_tag = rsp_tag;
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge, valid still high.
    task automatic push(input logic s, input logic [TAG_W-1:0] t, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        req_valid = 1'b1; req_sub = s; req_tag = t; req_a = a; req_b = b;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 300) break;
        end
        if (n > 300) begin
            checks++; failures++;
            $display("FAIL push_timeout: req_ready=%0b required 1", req_ready);
            req_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((iss_q.size() != 0 || rsp_q.size() != 0 || fifo_count != 0 || rsp_valid) && n < 2000) begin
            cycles(1);
            n++;
        end
        chk("drain_done", 64'(n < 2000), 64'd1);
        cycles(2);
    endtask

    task automatic run_tests();
        int e0, r0;
        cycles(1);
        @(negedge clk);
        chk("reset_count", 64'(fifo_count), 64'd0);
        chk("reset_ready", 64'(req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_fadd_en", 64'(fadd_en), 64'd0);
        @(posedge clk);
        #1;

        rsp_ready = 1'b1;
        e0 = en_pulses;
        push(1'b0, 4'd3, 32'h3F80_0000, 32'h3F80_0000);
        req_valid = 1'b0;
        drain();
        chk("add_en_pulses", 64'(en_pulses - e0), 64'd1);
        chk("add_fadd_b", 64'(last_fadd_b), 64'h3F80_0000);
        chk("add_rsp_data", 64'(last_rsp_data), 64'h4000_0000);
        chk("add_rsp_tag", 64'(last_rsp_tag), 64'd3);

        push(1'b1, 4'd5, 32'h4040_0000, 32'h3F80_0000);
        req_valid = 1'b0;
        drain();
        chk("sub_fadd_b", 64'(last_fadd_b), 64'hBF80_0000);
        chk("sub_rsp_data", 64'(last_rsp_data), 64'h4000_0000);

        rsp_ready = 1'b0;
        r0 = rsp_n;
        for (int i = 1; i <= 5; i++) push(1'b0, TAG_W'(i), $urandom, $urandom);
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("full_count", 64'(fifo_count), 64'd4);
            chk("full_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain();
        chk("full_rsp_total", 64'(rsp_n - r0), 64'd5);

        busy_force = 1'b1;
        push(1'b1, 4'd9, $urandom | 32'd1, $urandom);
        req_valid = 1'b0;
        e0 = en_pulses;
        cycles(10);
        chk("busy_no_issue", 64'(en_pulses - e0), 64'd0);
        busy_force = 1'b0;
        @(negedge clk);
        chk("busy_fall_same", 64'(fadd_en), 64'd0);
        @(negedge clk);
        chk("busy_fall_next", 64'(fadd_en), 64'd1);
        @(posedge clk);
        #1;
        drain();

        lat_fixed = 30;
        r0 = rsp_n;
        for (int i = 0; i < 3; i++) push(1'b0, TAG_W'(10 + i), $urandom | 32'd1, $urandom);
        req_valid = 1'b0;
        cycles(2);
        chk("pre_reset_count", 64'(fifo_count), 64'd2);
        rstn = 1'b0;
        cycles(1);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_fadd_en", 64'(fadd_en), 64'd0);
        chk("rst_fadd_a", 64'(fadd_a), 64'd0);
        chk("rst_fadd_b", 64'(fadd_b), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        cycles(40);
        chk("rst_no_rsp", 64'(rsp_n - r0), 64'd0);
        lat_fixed = 0;

        r0 = rsp_n;
        toggling = 1'b1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    push(1'($urandom), TAG_W'(i), $urandom, $urandom);
                    if ($urandom_range(0, 2) == 0) begin
                        req_valid = 1'b0;
                        cycles($urandom_range(1, 3));
                    end
                end
                req_valid = 1'b0;
                toggling = 1'b0;
            end
            begin
                while (toggling) begin
                    rsp_ready = 1'($urandom);
                    cycles(1);
                end
            end
        join
        rsp_ready = 1'b1;
        drain();
        chk("rand_rsp_total", 64'(rsp_n - r0), 64'd40);
    endtask

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_sub = 1'b0; req_tag = '0;
        req_a = '0; req_b = '0; rsp_ready = 1'b0; busy_force = 1'b0; toggling = 1'b0;
        prev_valid = 1'b0; prev_hs = 1'b0; prev_en = 1'b0; prev_data = '0; prev_tag = '0;
        last_fadd_b = '0; last_rsp_data = '0; last_rsp_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        fork
            monitor();
            run_tests();
            begin
                repeat (20000) @(posedge clk);
                checks++; failures++;
                $display("FAIL watchdog: cycle budget of 20000 exhausted");
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
